// File: rtl/load_store_unit.sv
// Handshaked load/store unit: decodes funct3, drives aligned bus beats with byte
// enables, splits word-crossing accesses into two beats and extends load data.
module load_store_unit #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_f3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        dbg_state
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  // Handshakes: core request is taken on req_valid && req_ready (IDLE only);
  // a bus beat completes on mem_valid && mem_ready and its read data arrives
  // on mem_rvalid in RSP0/RSP1; rsp_valid is a single-cycle pulse in DONE.
  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_RSP0, S_REQ1, S_RSP1, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic              r_we, r_uns, r_cross, r_err;
  logic [1:0]        r_sz;
  logic [OFF_W-1:0]  r_off;
  logic [ADDR_W-1:0] r_base;
  logic [DATA_W-1:0] r_wdata;
  logic [2*DATA_W-1:0] r_rbuf;

  logic              w_dec_ok, w_dec_uns, w_dec_cross, w_dec_err;
  logic [1:0]        w_dec_sz;
  logic [3:0]        w_dec_nbytes;
  logic [OFF_W-1:0]  w_dec_off;

  always_comb begin
    w_dec_ok  = 1'b1;
    w_dec_sz  = 2'd0;
    w_dec_uns = 1'b0;
    case (req_f3)
      3'b000: w_dec_sz = 2'd0;
      3'b001: w_dec_sz = 2'd1;
      3'b010: w_dec_sz = 2'd2;
      3'b011: begin w_dec_sz = 2'd3; w_dec_ok = (DATA_W == 64); end
      3'b100: begin w_dec_sz = 2'd0; w_dec_uns = 1'b1; w_dec_ok = !req_we; end
      3'b101: begin w_dec_sz = 2'd1; w_dec_uns = 1'b1; w_dec_ok = !req_we; end
      3'b110: begin w_dec_sz = 2'd2; w_dec_uns = 1'b1; w_dec_ok = !req_we && (DATA_W == 64); end
      default: w_dec_ok = 1'b0;
    endcase
    w_dec_nbytes = 4'd1 << w_dec_sz;
    w_dec_off    = req_addr[OFF_W-1:0];
    w_dec_cross  = (5'(w_dec_off) + 5'(w_dec_nbytes)) > 5'(NB);
    w_dec_err    = !w_dec_ok || (w_dec_cross && (MISALIGN_SPLIT == 0));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_state_nxt = w_dec_err ? S_DONE : S_REQ0;
      S_REQ0: if (mem_ready) w_state_nxt = !r_we ? S_RSP0 : (r_cross ? S_REQ1 : S_DONE);
      S_RSP0: if (mem_rvalid) w_state_nxt = r_cross ? S_REQ1 : S_DONE;
      S_REQ1: if (mem_ready) w_state_nxt = r_we ? S_DONE : S_RSP1;
      S_RSP1: if (mem_rvalid) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_cross <= 1'b0;
      r_err   <= 1'b0;
      r_sz    <= 2'd0;
      r_off   <= '0;
      r_base  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && req_valid) begin
        r_we    <= req_we;
        r_uns   <= w_dec_uns;
        r_cross <= w_dec_cross;
        r_err   <= w_dec_err;
        r_sz    <= w_dec_sz;
        r_off   <= w_dec_off;
        r_base  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        r_wdata <= req_we ? req_wdata : '0;
        r_rbuf  <= '0;
      end
      if (r_state == S_RSP0 && mem_rvalid) r_rbuf[DATA_W-1:0] <= mem_rdata;
      if (r_state == S_RSP1 && mem_rvalid) r_rbuf[2*DATA_W-1:DATA_W] <= mem_rdata;
    end
  end

  // Both beats come from one double-width shift: low half is beat 0, high half beat 1.
  logic [3:0]          w_nbytes;
  logic [NB-1:0]       w_mask;
  logic [2*NB-1:0]     w_be_full;
  logic [2*DATA_W-1:0] w_wd_full;
  logic [DATA_W-1:0]   w_raw, w_keep, w_top, w_ext;
  logic                w_sign, w_beat1;

  always_comb begin
    w_nbytes = 4'd1 << r_sz;
    w_mask   = '0;
    w_keep   = '0;
    for (int b = 0; b < NB; b++) begin
      w_mask[b]         = (b < int'(w_nbytes));
      w_keep[8*b +: 8]  = {8{w_mask[b]}};
    end
    w_be_full = {{NB{1'b0}}, w_mask} << r_off;
    w_wd_full = {{DATA_W{1'b0}}, r_wdata} << {r_off, 3'b000};
    w_raw     = DATA_W'(r_rbuf >> {r_off, 3'b000});
    // Highest kept bit is the sign bit of the loaded value.
    w_top     = w_keep & ~(w_keep >> 1);
    w_sign    = (|(w_raw & w_top)) && !r_uns;
    w_ext     = (w_raw & w_keep) | (w_sign ? ~w_keep : '0);
  end

  assign w_beat1   = (r_state == S_REQ1);
  assign mem_valid = (r_state == S_REQ0) || w_beat1;
  assign mem_we    = mem_valid && r_we;
  assign mem_addr  = !mem_valid ? '0 : (w_beat1 ? r_base + ADDR_W'(NB) : r_base);
  assign mem_be    = !mem_valid ? '0 : (w_beat1 ? w_be_full[2*NB-1:NB] : w_be_full[NB-1:0]);
  assign mem_wdata = !mem_we ? '0 : (w_beat1 ? w_wd_full[2*DATA_W-1:DATA_W] : w_wd_full[DATA_W-1:0]);

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_err   = rsp_valid && r_err;
  assign rsp_rdata = (rsp_valid && !r_err && !r_we) ? w_ext : '0;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: 32-bit split, 32-bit no-split and 64-bit
// instances behind one bus/core model, with hand-computed expectations.
module tb_load_store_unit;
  logic        clk, rst;
  int          sel;
  logic        req_valid, req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_ready, mem_rvalid;
  logic [63:0] mem_rdata;

  logic        o0_req_ready, o0_rsp_valid, o0_rsp_err, o0_mem_valid, o0_mem_we;
  logic [31:0] o0_rsp_rdata, o0_mem_addr, o0_mem_wdata;
  logic [3:0]  o0_mem_be;
  logic [2:0]  dbg0;
  logic        o1_req_ready, o1_rsp_valid, o1_rsp_err, o1_mem_valid, o1_mem_we;
  logic [31:0] o1_rsp_rdata, o1_mem_addr, o1_mem_wdata;
  logic [3:0]  o1_mem_be;
  logic [2:0]  dbg1;
  logic        o2_req_ready, o2_rsp_valid, o2_rsp_err, o2_mem_valid, o2_mem_we;
  logic [63:0] o2_rsp_rdata, o2_mem_wdata;
  logic [31:0] o2_mem_addr;
  logic [7:0]  o2_mem_be;
  logic [2:0]  dbg2;

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel == 0), .req_ready(o0_req_ready),
    .req_we(req_we), .req_f3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .rsp_valid(o0_rsp_valid), .rsp_err(o0_rsp_err), .rsp_rdata(o0_rsp_rdata),
    .mem_valid(o0_mem_valid), .mem_ready(mem_ready), .mem_we(o0_mem_we),
    .mem_addr(o0_mem_addr), .mem_be(o0_mem_be), .mem_wdata(o0_mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]), .dbg_state(dbg0));

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) u_dut32_ns (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel == 1), .req_ready(o1_req_ready),
    .req_we(req_we), .req_f3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .rsp_valid(o1_rsp_valid), .rsp_err(o1_rsp_err), .rsp_rdata(o1_rsp_rdata),
    .mem_valid(o1_mem_valid), .mem_ready(mem_ready), .mem_we(o1_mem_we),
    .mem_addr(o1_mem_addr), .mem_be(o1_mem_be), .mem_wdata(o1_mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]), .dbg_state(dbg1));

  load_store_unit #(.DATA_W(64), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel == 2), .req_ready(o2_req_ready),
    .req_we(req_we), .req_f3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(o2_rsp_valid), .rsp_err(o2_rsp_err), .rsp_rdata(o2_rsp_rdata),
    .mem_valid(o2_mem_valid), .mem_ready(mem_ready), .mem_we(o2_mem_we),
    .mem_addr(o2_mem_addr), .mem_be(o2_mem_be), .mem_wdata(o2_mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .dbg_state(dbg2));

  logic        obs_req_ready, obs_rsp_valid, obs_rsp_err, obs_mem_valid, obs_mem_we;
  logic [63:0] obs_rsp_rdata, obs_mem_wdata;
  logic [31:0] obs_mem_addr;
  logic [7:0]  obs_mem_be;
  logic [2:0]  obs_state;

  always_comb begin
    obs_req_ready = o0_req_ready;  obs_rsp_valid = o0_rsp_valid;
    obs_rsp_err   = o0_rsp_err;    obs_rsp_rdata = {32'd0, o0_rsp_rdata};
    obs_mem_valid = o0_mem_valid;  obs_mem_we    = o0_mem_we;
    obs_mem_addr  = o0_mem_addr;   obs_mem_be    = {4'd0, o0_mem_be};
    obs_mem_wdata = {32'd0, o0_mem_wdata}; obs_state = dbg0;
    if (sel == 1) begin
      obs_req_ready = o1_req_ready;  obs_rsp_valid = o1_rsp_valid;
      obs_rsp_err   = o1_rsp_err;    obs_rsp_rdata = {32'd0, o1_rsp_rdata};
      obs_mem_valid = o1_mem_valid;  obs_mem_we    = o1_mem_we;
      obs_mem_addr  = o1_mem_addr;   obs_mem_be    = {4'd0, o1_mem_be};
      obs_mem_wdata = {32'd0, o1_mem_wdata}; obs_state = dbg1;
    end else if (sel == 2) begin
      obs_req_ready = o2_req_ready;  obs_rsp_valid = o2_rsp_valid;
      obs_rsp_err   = o2_rsp_err;    obs_rsp_rdata = o2_rsp_rdata;
      obs_mem_valid = o2_mem_valid;  obs_mem_we    = o2_mem_we;
      obs_mem_addr  = o2_mem_addr;   obs_mem_be    = o2_mem_be;
      obs_mem_wdata = o2_mem_wdata;  obs_state = dbg2;
    end
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Results of the last transaction
  int          n_beats, rsp_cyc;
  logic        rsp_seen, rsp_err_v;
  logic [63:0] rsp_data_v;
  logic [31:0] b_addr[2];
  logic [7:0]  b_be[2];
  logic [63:0] b_wd[2];
  logic        b_we[2];
  int          b_cyc[2];

  // Drives one request and acts as the bus. Call inside an IDLE cycle before its
  // rising edge; returns at the falling edge of the cycle after the response.
  task automatic run_req(input int s, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rd0, input logic [63:0] rd1,
                         input int stall);
    int          stall_left, beat;
    logic        pend_rv, h_ok;
    logic [63:0] pend_data, h_wd;
    logic [31:0] h_addr;
    logic [7:0]  h_be;
    logic        h_we;
    logic [63:0] exp_d;
    sel = s; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    mem_ready = (stall == 0); mem_rvalid = 1'b0;
    stall_left = stall; beat = 0; pend_rv = 1'b0; pend_data = '0; h_ok = 1'b0;
    h_wd = '0; h_addr = '0; h_be = '0; h_we = 1'b0;
    rsp_seen = 1'b0; rsp_cyc = -1; rsp_err_v = 1'b0; rsp_data_v = '0;
    b_cyc[0] = -1; b_cyc[1] = -1;
    check("req_ready_idle", obs_req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_f3 = 3'b111; req_addr = 32'hDEAD_BEE7; req_wdata = '1;
    for (int c = 1; c <= 30 && !rsp_seen; c++) begin
      @(negedge clk);
      if (obs_mem_valid && beat < 2) begin
        if (h_ok) begin
          check("stall_addr", obs_mem_addr, h_addr);
          check("stall_be", obs_mem_be, h_be);
          check("stall_wdata", obs_mem_wdata, h_wd);
          check("stall_we", obs_mem_we, h_we);
        end else b_cyc[beat] = c;
        b_addr[beat] = obs_mem_addr; b_be[beat] = obs_mem_be;
        b_wd[beat] = obs_mem_wdata; b_we[beat] = obs_mem_we;
        if (mem_ready) begin
          if (!we) begin pend_rv = 1'b1; pend_data = (beat == 0) ? rd0 : rd1; end
          beat++;
          h_ok = 1'b0;
        end else begin
          stall_left--;
          h_ok = 1'b1; h_addr = obs_mem_addr; h_be = obs_mem_be; h_wd = obs_mem_wdata; h_we = obs_mem_we;
        end
      end
      if (obs_rsp_valid) begin
        rsp_seen = 1'b1; rsp_cyc = c; rsp_err_v = obs_rsp_err; rsp_data_v = obs_rsp_rdata;
      end
      @(posedge clk); #1;
      mem_rvalid = pend_rv;
      mem_rdata  = pend_rv ? pend_data : 64'h5A5A_A5A5_3C3C_C3C3;
      pend_rv    = 1'b0;
      mem_ready  = (stall_left == 0);
    end
    mem_rvalid = 1'b0;
    n_beats = beat;
    check("rsp_seen", rsp_seen, 1);
    if (exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      check("rsp_rdata", rsp_data_v, exp_d);
    end
    @(negedge clk);
    check("rsp_pulse_end", obs_rsp_valid, 0);
    check("rsp_rdata_idle", obs_rsp_rdata, 0);
    check("req_ready_after", obs_req_ready, 1);
  endtask

  task automatic expect_rsp(input string tag, input int cyc, input logic err, input int beats);
    check({tag, "_cyc"}, 64'(rsp_cyc), 64'(cyc));
    check({tag, "_err"}, rsp_err_v, err);
    check({tag, "_beats"}, 64'(n_beats), 64'(beats));
  endtask

  task automatic expect_beat(input string tag, input int i, input logic we, input logic [31:0] addr,
                             input logic [7:0] be, input logic [63:0] wd);
    check({tag, "_we"}, b_we[i], we);
    check({tag, "_addr"}, b_addr[i], addr);
    check({tag, "_be"}, b_be[i], be);
    check({tag, "_wdata"}, b_wd[i], wd);
  endtask

  initial begin
    sel = 0; req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'b000; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req_ready", obs_req_ready, 0);
    check("rst_mem_valid", obs_mem_valid, 0);
    check("rst_mem_we", obs_mem_we, 0);
    check("rst_mem_addr", obs_mem_addr, 0);
    check("rst_mem_be", obs_mem_be, 0);
    check("rst_mem_wdata", obs_mem_wdata, 0);
    check("rst_rsp_valid", obs_rsp_valid, 0);
    check("rst_rsp_err", obs_rsp_err, 0);
    check("rst_rsp_rdata", obs_rsp_rdata, 0);
    check("rst_state", obs_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    // Aligned LW
    exp_q.push_back(64'h8899_AABB);
    run_req(0, 1'b0, 3'b010, 32'h1000, 64'h0, 64'h8899_AABB, 64'h0, 0);
    expect_rsp("lw", 3, 1'b0, 1);
    expect_beat("lw_b0", 0, 1'b0, 32'h1000, 8'h0F, 64'h0);

    // LB vs LBU on lane 1
    exp_q.push_back(64'hFFFF_FFF0);
    run_req(0, 1'b0, 3'b000, 32'h1001, 64'h0, 64'h0000_F000, 64'h0, 0);
    expect_rsp("lb", 3, 1'b0, 1);
    expect_beat("lb_b0", 0, 1'b0, 32'h1000, 8'h02, 64'h0);
    exp_q.push_back(64'h0000_00F0);
    run_req(0, 1'b0, 3'b100, 32'h1001, 64'h0, 64'h0000_F000, 64'h0, 0);
    expect_rsp("lbu", 3, 1'b0, 1);

    // Split SW
    exp_q.push_back(64'h0);
    run_req(0, 1'b1, 3'b010, 32'h1003, 64'h1122_3344, 64'h0, 64'h0, 0);
    expect_rsp("sw_split", 3, 1'b0, 2);
    expect_beat("sw_b0", 0, 1'b1, 32'h1000, 8'h08, 64'h4400_0000);
    expect_beat("sw_b1", 1, 1'b1, 32'h1004, 8'h07, 64'h0011_2233);
    check("sw_b1_cyc", 64'(b_cyc[1]), 64'd2);

    // Split LH
    exp_q.push_back(64'hFFFF_FF80);
    run_req(0, 1'b0, 3'b001, 32'h1003, 64'h0, 64'h8000_0000, 64'h0000_00FF, 0);
    expect_rsp("lh_split", 5, 1'b0, 2);
    expect_beat("lh_b0", 0, 1'b0, 32'h1000, 8'h08, 64'h0);
    expect_beat("lh_b1", 1, 1'b0, 32'h1004, 8'h01, 64'h0);
    check("lh_b1_cyc", 64'(b_cyc[1]), 64'd3);

    // Same LH without splitting support
    exp_q.push_back(64'h0);
    run_req(1, 1'b0, 3'b001, 32'h1003, 64'h0, 64'h8000_0000, 64'h0000_00FF, 0);
    expect_rsp("lh_nosplit", 1, 1'b1, 0);

    // Illegal funct3 codes on the 32-bit bus
    exp_q.push_back(64'h0);
    run_req(0, 1'b0, 3'b011, 32'h1000, 64'h0, 64'h1234_5678, 64'h0, 0);
    expect_rsp("ld32", 1, 1'b1, 0);
    exp_q.push_back(64'h0);
    run_req(0, 1'b1, 3'b011, 32'h1000, 64'hFFFF_FFFF, 64'h0, 64'h0, 0);
    expect_rsp("sd32", 1, 1'b1, 0);
    exp_q.push_back(64'h0);
    run_req(0, 1'b1, 3'b100, 32'h1000, 64'hFFFF_FFFF, 64'h0, 64'h0, 0);
    expect_rsp("sbu", 1, 1'b1, 0);

    // Misaligned SH that stays inside the word
    exp_q.push_back(64'h0);
    run_req(0, 1'b1, 3'b001, 32'h1001, 64'h0000_BEEF, 64'h0, 64'h0, 0);
    expect_rsp("sh_mis", 2, 1'b0, 1);
    expect_beat("sh_b0", 0, 1'b1, 32'h1000, 8'h06, 64'h00BE_EF00);

    // Stalled SW: bus held not-ready for 5 cycles
    exp_q.push_back(64'h0);
    run_req(0, 1'b1, 3'b010, 32'h1008, 64'hCAFE_F00D, 64'h0, 64'h0, 5);
    expect_rsp("sw_stall", 7, 1'b0, 1);
    expect_beat("sw_stall_b0", 0, 1'b1, 32'h1008, 8'h0F, 64'hCAFE_F00D);

    // 64-bit bus
    exp_q.push_back(64'h0);
    run_req(2, 1'b1, 3'b011, 32'h2000, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 0);
    expect_rsp("sd64", 2, 1'b0, 1);
    expect_beat("sd64_b0", 0, 1'b1, 32'h2000, 8'hFF, 64'h0123_4567_89AB_CDEF);
    exp_q.push_back(64'h0000_0000_F000_0000);
    run_req(2, 1'b0, 3'b110, 32'h2004, 64'h0, 64'hF000_0000_0000_0000, 64'h0, 0);
    expect_rsp("lwu64", 3, 1'b0, 1);
    expect_beat("lwu64_b0", 0, 1'b0, 32'h2000, 8'hF0, 64'h0);
    exp_q.push_back(64'h0000_0000_2211_8877);
    run_req(2, 1'b0, 3'b010, 32'h2006, 64'h0, 64'h8877_0000_0000_0000, 64'h0000_0000_0000_2211, 0);
    expect_rsp("lw64_split", 5, 1'b0, 2);
    expect_beat("lw64_b0", 0, 1'b0, 32'h2000, 8'hC0, 64'h0);
    expect_beat("lw64_b1", 1, 1'b0, 32'h2008, 8'h03, 64'h0);

    // Reset while waiting for read data
    sel = 0; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h1010; req_valid = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_state", obs_state, 64'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", obs_req_ready, 1);
    check("midrst_state", obs_state, 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("late_rvalid_rsp", obs_rsp_valid, 0);
      check("late_rvalid_mem", obs_mem_valid, 0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
